axi4_lsu_master: RTL

- Single-outstanding AXI4 initiator that turns the core's simple load/store request interface into single-beat AXI4 read or write transactions.
- Drives the bus toward responders such as the CLINT timer, the UART and SRAM through the crossbar.
- Returns read data and a combined error flag to the requester.

---
 rtl/axi4_lsu_master_if.sv | 71 +++++++
 rtl/axi4_lsu_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/axi4_lsu_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lsu_master_if
// Description : Single-beat AXI4 bus bundle (AR/R/AW/W/B) shared by the LSU
//               initiator and its responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_lsu_master_if #(
    parameter int DATA_W = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           araddr;
    logic [3:0]            arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic [3:0]            rid;
    logic                  rlast;

    logic                  awvalid;
    logic                  awready;
    logic [31:0]           awaddr;
    logic [3:0]            awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [3:0]            bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lsu_master
// Description : Single-outstanding AXI4 initiator turning load/store requests
//               into single-beat reads/writes. Optional macro
//               AXI_ALIGN_CHECK_EN rejects misaligned requests locally.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lsu_master #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         DATA_W = 32
) (
    input  wire logic                clock,
    input  wire logic                reset,
    input  wire logic                req_valid,
    output logic                     req_ready,
    input  wire logic                req_wen,
    input  wire logic [31:0]         req_addr,
    input  wire logic [2:0]          req_size,
    input  wire logic [DATA_W-1:0]   req_wdata,
    input  wire logic [DATA_W/8-1:0] req_wstrb,
    output logic                     resp_valid,
    input  wire logic                resp_ready,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     resp_err,
    axi4_lsu_master_if.master        axi
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RADDR = 3'd1;
    localparam logic [2:0] c_ST_RDATA = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_WRESP = 3'd4;
    localparam logic [2:0] c_ST_RESP  = 3'd5;
    localparam logic [1:0] c_BURST_INCR = 2'b01;

    logic [2:0]          r_state;
    logic [31:0]         r_addr;
    logic [2:0]          r_size;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_arvalid, r_awvalid, r_wvalid, r_rready, r_bready;
    logic                r_resp_valid, r_resp_err;
    logic [DATA_W-1:0]   r_resp_rdata;

    logic w_misaligned;
    logic w_aw_done, w_w_done;

`ifdef AXI_ALIGN_CHECK_EN
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            3'd0:    w_misaligned = 1'b0;
            3'd1:    w_misaligned = req_addr[0];
            3'd2:    w_misaligned = |req_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    // A channel counts as done once its valid has dropped or it fires this cycle.
    assign w_aw_done = !r_awvalid || axi.awready;
    assign w_w_done  = !r_wvalid  || axi.wready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_arvalid    <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_rready     <= 1'b0;
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_size  <= req_size;
                        r_wdata <= req_wdata;
                        r_wstrb <= req_wstrb;
                        if (w_misaligned) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_state      <= c_ST_RESP;
                        end else if (req_wen) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= c_ST_WRITE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= c_ST_RADDR;
                        end
                    end
                end
                c_ST_RADDR: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= c_ST_RDATA;
                    end
                end
                c_ST_RDATA: begin
                    if (axi.rvalid) begin
                        r_rready     <= 1'b0;
                        r_resp_rdata <= axi.rdata;
                        r_resp_err   <= (axi.rresp != 2'b00) || (axi.rid != AXI_ID) || !axi.rlast;
                        r_resp_valid <= 1'b1;
                        r_state      <= c_ST_RESP;
                    end
                end
                c_ST_WRITE: begin
                    if (r_awvalid && axi.awready) r_awvalid <= 1'b0;
                    if (r_wvalid && axi.wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= c_ST_WRESP;
                    end
                end
                c_ST_WRESP: begin
                    if (axi.bvalid) begin
                        r_bready     <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_err   <= (axi.bresp != 2'b00) || (axi.bid != AXI_ID);
                        r_resp_valid <= 1'b1;
                        r_state      <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == c_ST_IDLE);
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;

    assign axi.arvalid = r_arvalid;
    assign axi.araddr  = r_addr;
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = r_size;
    assign axi.arburst = c_BURST_INCR;
    assign axi.rready  = r_rready;

    assign axi.awvalid = r_awvalid;
    assign axi.awaddr  = r_addr;
    assign axi.awid    = AXI_ID;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = r_size;
    assign axi.awburst = c_BURST_INCR;
    assign axi.wvalid  = r_wvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wlast   = 1'b1;
    assign axi.bready  = r_bready;

endmodule
`default_nettype wire
